// File: rtl/poly_eval.sv
// Polynomial evaluator: y = sum c[i]*x**i mod 2**DATA_W, one Horner step per cycle.
// Coefficients live in a local register file written while the block is idle.
module poly_eval #(
  parameter int DATA_W = 32,
  parameter int DEGREE = 6,
  parameter int CW     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              stall,
  output logic [DATA_W-1:0] returndata,
  input  logic [DATA_W-1:0] idx,
  input  logic              coef_we,
  input  logic [CW-1:0]     coef_addr,
  input  logic [DATA_W-1:0] coef_wdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_INIT = CW'(DEGREE - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] x_r;
  logic [DATA_W-1:0] acc_r;
  logic [DATA_W-1:0] ret_r;
  logic [CW-1:0]     cnt_r;
  logic [DATA_W-1:0] coef_r      [0:DEGREE];
  // Snapshot taken at call acceptance so a same-cycle write cannot leak into the call.
  logic [DATA_W-1:0] coef_work_r [0:DEGREE-1];
  logic [DATA_W-1:0] sel_s;
  logic [DATA_W-1:0] horner_s;
  logic              accept_s;

  assign accept_s   = (state_r == IDLE) && start;
  assign busy       = busy_r;
  assign done       = done_r;
  assign returndata = ret_r;

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = start ? CALC : IDLE;
      CALC:    state_nxt_s = (cnt_r == '0) ? DONE : CALC;
      DONE:    state_nxt_s = stall ? DONE : IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register with registered busy/done flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Coefficient select and one Horner step, truncated to DATA_W bits.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < DEGREE; i++) begin
      sel_s = (cnt_r == CW'(i)) ? coef_work_r[i] : sel_s;
    end
    horner_s = acc_r * x_r + sel_s;
  end

  // Datapath, coefficient storage and result register.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_r   <= '0;
      acc_r <= '0;
      ret_r <= '0;
      cnt_r <= '0;
      for (int i = 0; i <= DEGREE; i++) begin
        coef_r[i] <= '0;
      end
      for (int i = 0; i < DEGREE; i++) begin
        coef_work_r[i] <= '0;
      end
    end else begin
      if (accept_s) begin
        x_r   <= idx;
        acc_r <= coef_r[DEGREE];
        cnt_r <= CNT_INIT;
        for (int i = 0; i < DEGREE; i++) begin
          coef_work_r[i] <= coef_r[i];
        end
      end else if (state_r == CALC) begin
        acc_r <= horner_s;
        if (cnt_r == '0) begin
          ret_r <= horner_s;
        end else begin
          cnt_r <= cnt_r - CW'(1);
        end
      end
      if ((state_r == IDLE) && coef_we) begin
        for (int i = 0; i <= DEGREE; i++) begin
          if (coef_addr == CW'(i)) begin
            coef_r[i] <= coef_wdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_poly_eval.sv
// Directed plus randomized bench for poly_eval; expected results come from a
// direct power-sum reference model of the coefficient set.
module tb_poly_eval;
  localparam int DATA_W = 32;
  localparam int DEGREE = 6;
  localparam int CW     = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic              stall;
  logic [DATA_W-1:0] returndata;
  logic [DATA_W-1:0] idx;
  logic              coef_we;
  logic [CW-1:0]     coef_addr;
  logic [DATA_W-1:0] coef_wdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int a1, a2, dummy;
  logic [DATA_W-1:0] c_model [0:DEGREE];

  poly_eval #(.DATA_W(DATA_W), .DEGREE(DEGREE), .CW(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .stall(stall), .returndata(returndata), .idx(idx), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // y = sum c[i] * x**i, each power built by repeated multiplication
  function automatic logic [31:0] ref_eval(input logic [31:0] x);
    logic [31:0] sum;
    logic [31:0] p;
    sum = 32'd0;
    for (int i = 0; i <= DEGREE; i++) begin
      p = 32'd1;
      for (int j = 0; j < i; j++) p = p * x;
      sum = sum + c_model[i] * p;
    end
    return sum;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_coef(input logic [3:0] a, input logic [31:0] d);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    tick();
    coef_we = 1'b0;
    if (a <= 4'd6) c_model[a] = d;
  endtask

  task automatic run_call(input string tag, input logic [31:0] x, input logic [31:0] exp,
                          input int nstall, input bit disturb, output int acc_cyc);
    idx = x; start = 1'b1; acc_cyc = cyc;
    tick();
    start = 1'b0;
    idx = $urandom;
    for (int k = 1; k <= DEGREE; k++) begin
      check({tag, ".calc_busy"}, {31'd0, busy}, 32'd1);
      check({tag, ".calc_done"}, {31'd0, done}, 32'd0);
      if (disturb && k == 2) begin
        coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 32'd9;
      end else begin
        coef_we = 1'b0;
      end
      tick();
    end
    coef_we = 1'b0;
    stall = (nstall > 0);
    if (disturb) start = 1'b1;
    for (int s = 0; s < nstall; s++) begin
      check({tag, ".stall_done"}, {31'd0, done}, 32'd1);
      check({tag, ".stall_busy"}, {31'd0, busy}, 32'd1);
      check({tag, ".stall_data"}, returndata, exp);
      tick();
    end
    stall = 1'b0; start = 1'b0;
    check({tag, ".done"}, {31'd0, done}, 32'd1);
    check({tag, ".result"}, returndata, exp);
    tick();
    check({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".idle_done"}, {31'd0, done}, 32'd0);
    check({tag, ".hold"}, returndata, exp);
    if (disturb) begin
      tick();
      check({tag, ".no_second_call"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] x;
    reset = 1'b1; start = 1'b0; stall = 1'b0; coef_we = 1'b0;
    idx = 32'd0; coef_addr = 4'd0; coef_wdata = 32'd0;
    for (int i = 0; i <= DEGREE; i++) c_model[i] = 32'd0;
    tick();
    tick();
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.data", returndata, 32'd0);
    reset = 1'b0;

    // basic call, coefficient writes right after reset
    for (int i = 0; i <= DEGREE; i++) set_coef(4'(i), 32'd1);
    run_call("basic", 32'd2, 32'd127, 0, 1'b0, dummy);

    for (int i = 0; i < DEGREE; i++) set_coef(4'(i), 32'd0);
    run_call("single", 32'd3, 32'h0000_02D9, 0, 1'b0, dummy);

    set_coef(4'd6, 32'd0); set_coef(4'd2, 32'd1); set_coef(4'd0, 32'd5);
    run_call("wrap", 32'h0001_0000, 32'h0000_0005, 0, 1'b0, dummy);

    // stall, ignored starts during DONE, dropped write during CALC
    for (int i = 0; i <= DEGREE; i++) set_coef(4'(i), 32'd1);
    run_call("stall", 32'd2, 32'd127, 3, 1'b1, dummy);
    run_call("c0_frozen", 32'd1, 32'd7, 0, 1'b0, dummy);

    // write coincident with start: call sees old value, write still lands
    coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 32'd100;
    run_call("wr_start_old", 32'd1, 32'd7, 0, 1'b0, dummy);
    c_model[0] = 32'd100;
    run_call("wr_start_new", 32'd1, 32'd106, 0, 1'b0, dummy);

    // out-of-range addresses must not alias onto real coefficients
    set_coef(4'd7, 32'd55); set_coef(4'd8, 32'd3); set_coef(4'd15, 32'd77);
    run_call("oob_drop", 32'd2, ref_eval(32'd2), 0, 1'b0, dummy);

    for (int n = 0; n < 12; n++) begin
      for (int w = 0; w < 3; w++) set_coef(4'($urandom_range(0, 15)), $urandom);
      x = $urandom;
      run_call("random", x, ref_eval(x), $urandom_range(0, 2), 1'b0, dummy);
    end

    for (int i = 0; i <= DEGREE; i++) set_coef(4'(i), 32'd1);
    run_call("b2b_1", 32'd1, 32'd7, 0, 1'b0, a1);
    run_call("b2b_2", 32'd2, 32'd127, 0, 1'b0, a2);
    check("b2b.spacing", 32'(a2 - a1), 32'd8);

    // reset in the third CALC cycle
    idx = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset.busy", {31'd0, busy}, 32'd0);
    check("midreset.done", {31'd0, done}, 32'd0);
    check("midreset.data", returndata, 32'd0);
    for (int i = 0; i <= DEGREE; i++) c_model[i] = 32'd0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("midreset.no_done", {31'd0, done}, 32'd0);
    end
    run_call("post_reset", 32'd7, ref_eval(32'd7), 0, 1'b0, dummy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
